// File: rtl/y86_pkg.sv
// Shared definitions for the Y-86 execute stage: instruction codes, ALU
// operation encoding, condition-function codes, the condition-code struct
// and the branch/cmov condition evaluator.
package y86_pkg;

    localparam logic [3:0] IHalt   = 4'h0;
    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IRrmovq = 4'h2;  // also cmovXX
    localparam logic [3:0] IIrmovq = 4'h3;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;

    typedef enum logic [1:0] {
        AluAdd = 2'd0,
        AluSub = 2'd1,
        AluAnd = 2'd2,
        AluXor = 2'd3
    } alu_op_e;

    localparam logic [3:0] CAlways = 4'h0;
    localparam logic [3:0] CLe     = 4'h1;
    localparam logic [3:0] CL      = 4'h2;
    localparam logic [3:0] CE      = 4'h3;
    localparam logic [3:0] CNe     = 4'h4;
    localparam logic [3:0] CGe     = 4'h5;
    localparam logic [3:0] CG      = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    // Undefined condition functions evaluate as "always".
    function automatic logic eval_cond(cc_t cc, logic [3:0] fn);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (fn)
            CAlways: eval_cond = 1'b1;
            CLe:     eval_cond = lt | cc.zf;
            CL:      eval_cond = lt;
            CE:      eval_cond = cc.zf;
            CNe:     eval_cond = ~cc.zf;
            CGe:     eval_cond = ~lt;
            CG:      eval_cond = ~lt & ~cc.zf;
            default: eval_cond = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu64.sv
// Combinational 64-bit Y-86 ALU. Computes b op a (sub is b - a) and the
// matching ZF/SF/OF flags.
// Ports: op (alu_op_e), a, b (64-bit operands), result, zf, sf, of.
module y86_alu64
    import y86_pkg::*;
(
    input  alu_op_e      op,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    output logic [63:0]  result,
    output logic         zf,
    output logic         sf,
    output logic         of
);

    always_comb begin
        result = 64'd0;
        of     = 1'b0;
        unique case (op)
            AluAdd: begin
                result = b + a;
                of     = (a[63] == b[63]) & (result[63] != a[63]);
            end
            AluSub: begin
                result = b - a;
                of     = (b[63] != a[63]) & (result[63] != b[63]);
            end
            AluAnd: result = b & a;
            AluXor: result = b ^ a;
            default: result = 64'd0;
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];

endmodule

// File: rtl/y86_exec_stage.sv
// Registered Y-86 execute stage. Selects ALU operands from icode/ifun,
// computes valE, owns the condition-code register and evaluates the
// jXX/cmovXX condition, handing results on through a one-entry valid/ready
// register.
// Ports: clk, rst (sync active-high); in_valid/in_ready, icode, ifun, val_a,
// val_b, val_c from decode; out_valid/out_ready, out_icode, val_e, cnd to
// memory; cc_zf/cc_sf/cc_of architectural flags; err (EXEC_ERR_CHECK_EN only).
// Define EXEC_ERR_CHECK_EN to flag illegal ifun values instead of executing
// them as add / always.
module y86_exec_stage
    import y86_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [63:0]  val_a,
    input  logic [63:0]  val_b,
    input  logic [63:0]  val_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic [63:0]  val_e,
    output logic         cnd,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
`ifdef EXEC_ERR_CHECK_EN
    ,
    output logic         err
`endif
);

    logic        accept;
    logic        is_opq;
    logic        is_cond;
    logic        bad_ifun;
    alu_op_e     alu_op;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_res;
    logic        alu_zf;
    logic        alu_sf;
    logic        alu_of;

    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_icode_q;
    logic [63:0] val_e_q, val_e_d;
    logic        cnd_q, cnd_d;
    cc_t         cc_q;
    logic        cc_we;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign is_opq   = (icode == IOpq);
    assign is_cond  = (icode == IJxx) | (icode == IRrmovq);

`ifdef EXEC_ERR_CHECK_EN
    assign bad_ifun = (is_opq & (ifun > 4'd3)) | (is_cond & (ifun > 4'd6));
`else
    assign bad_ifun = 1'b0;
`endif

    // Operand select; unused icodes feed 0+0 so valE falls out as zero.
    always_comb begin
        alu_op = AluAdd;
        alu_a  = 64'd0;
        alu_b  = 64'd0;
        case (icode)
            IOpq: begin
                alu_a  = val_a;
                alu_b  = val_b;
                alu_op = (ifun > 4'd3) ? AluAdd : alu_op_e'(ifun[1:0]);
            end
            IIrmovq: alu_a = val_c;
            IRrmovq: alu_a = val_a;
            IRmmovq, IMrmovq: begin
                alu_a = val_c;
                alu_b = val_b;
            end
            IPushq, ICall: begin
                alu_a  = 64'd8;
                alu_b  = val_b;
                alu_op = AluSub;
            end
            IPopq, IRet: begin
                alu_a = 64'd8;
                alu_b = val_b;
            end
            default: ;
        endcase
    end

    y86_alu64 u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    always_comb begin
        val_e_d = bad_ifun ? 64'd0 : alu_res;
        // Condition reads the CC value from before this instruction.
        cnd_d   = is_cond & ~bad_ifun & eval_cond(cc_q, ifun);
        cc_we   = accept & is_opq & ~bad_ifun;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_icode_q <= 4'd0;
            val_e_q     <= 64'd0;
            cnd_q       <= 1'b0;
            cc_q        <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_icode_q <= icode;
                val_e_q     <= val_e_d;
                cnd_q       <= cnd_d;
            end
            if (cc_we) begin
                cc_q <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
            end
        end
    end

`ifdef EXEC_ERR_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= bad_ifun;
        end
    end
    assign err = err_q;
`endif

    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign val_e     = val_e_q;
    assign cnd       = cnd_q;
    assign cc_zf     = cc_q.zf;
    assign cc_sf     = cc_q.sf;
    assign cc_of     = cc_q.of;

endmodule

// File: tb/tb_y86_exec_stage.sv
// Directed self-checking bench for y86_exec_stage.
module tb_y86_exec_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_c;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [63:0] val_e;
    logic        cnd;
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;
`ifdef EXEC_ERR_CHECK_EN
    logic        err;
`endif

    int n_pass;
    int n_total;

    y86_exec_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .val_a     (val_a),
        .val_b     (val_b),
        .val_c     (val_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .val_e     (val_e),
        .cnd       (cnd),
        .cc_zf     (cc_zf),
        .cc_sf     (cc_sf),
        .cc_of     (cc_of)
`ifdef EXEC_ERR_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_valid = v;
        icode    = ic;
        ifun     = fn;
        val_a    = a;
        val_b    = b;
        val_c    = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100)
            $display("FAIL reset_cc got %b want 100", {cc_zf, cc_sf, cc_of});
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hs got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else n_pass++;
        n_total++;
        if (val_e !== 64'd0 || out_icode !== 4'd0 || cnd !== 1'b0)
            $display("FAIL reset_out got val_e=%h icode=%h cnd=%b want 0", val_e, out_icode, cnd);
        else n_pass++;
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        n_total++;
        if (val_e !== 64'h8000_0000_0000_0000 || out_valid !== 1'b1 || out_icode !== 4'h6)
            $display("FAIL add_val got %h v=%b ic=%h want 8000000000000000/1/6",
                     val_e, out_valid, out_icode);
        else n_pass++;
        n_total++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b011)
            $display("FAIL add_cc got %b want 011", {cc_zf, cc_sf, cc_of});
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL add_drain got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_sub_branch();
        // jl right after overflowing add: SF^OF = 0.
        drive(1'b1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        tick();
        n_total++;
        if (cnd !== 1'b0 || val_e !== 64'd0)
            $display("FAIL jl got cnd=%b val_e=%h want 0/0", cnd, val_e);
        else n_pass++;
        drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        tick();
        n_total++;
        if (val_e !== 64'd0 || {cc_zf, cc_sf, cc_of} !== 3'b100)
            $display("FAIL sub got val_e=%h cc=%b want 0/100", val_e, {cc_zf, cc_sf, cc_of});
        else n_pass++;
        drive(1'b1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        tick();
        n_total++;
        if (cnd !== 1'b1 || out_icode !== 4'h7)
            $display("FAIL je got cnd=%b icode=%h want 1/7", cnd, out_icode);
        else n_pass++;
        drive(1'b1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        tick();
        n_total++;
        if (cnd !== 1'b0)
            $display("FAIL jne got cnd=%b want 0", cnd);
        else n_pass++;
        // cmovle with ZF=1 moves val_a.
        drive(1'b1, 4'h2, 4'h1, 64'h1234, 64'd0, 64'd0);
        tick();
        n_total++;
        if (cnd !== 1'b1 || val_e !== 64'h1234)
            $display("FAIL cmovle got cnd=%b val_e=%h want 1/1234", cnd, val_e);
        else n_pass++;
    endtask

    task automatic test_addr();
        drive(1'b1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        tick();
        n_total++;
        if (val_e !== 64'hF8 || {cc_zf, cc_sf, cc_of} !== 3'b100)
            $display("FAIL pushq got val_e=%h cc=%b want f8/100", val_e, {cc_zf, cc_sf, cc_of});
        else n_pass++;
        drive(1'b1, 4'h5, 4'h0, 64'd0, 64'h10, 64'h8);
        tick();
        n_total++;
        if (val_e !== 64'h18)
            $display("FAIL mrmovq got val_e=%h want 18", val_e);
        else n_pass++;
        drive(1'b1, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
        tick();
        n_total++;
        if (val_e !== 64'h108)
            $display("FAIL popq got val_e=%h want 108", val_e);
        else n_pass++;
        drive(1'b1, 4'h3, 4'h0, 64'h55, 64'h66, 64'hABCD);
        tick();
        n_total++;
        if (val_e !== 64'hABCD || cnd !== 1'b0)
            $display("FAIL irmovq got val_e=%h cnd=%b want abcd/0", val_e, cnd);
        else n_pass++;
    endtask

    task automatic test_back_to_back_stall();
        drive(1'b1, 4'h6, 4'h3, 64'hF0, 64'hFF, 64'd0);
        tick();
        n_total++;
        if (val_e !== 64'h0F || cc_zf !== 1'b0)
            $display("FAIL xor got val_e=%h zf=%b want f/0", val_e, cc_zf);
        else n_pass++;
        out_ready = 1'b0;
        drive(1'b1, 4'h6, 4'h1, 64'd3, 64'd3, 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (in_ready !== 1'b0 || val_e !== 64'h0F || cc_zf !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL stall%0d got rdy=%b val_e=%h zf=%b v=%b want 0/f/0/1",
                         i, in_ready, val_e, cc_zf, out_valid);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL release_rdy got %b want 1", in_ready);
        else n_pass++;
        tick();
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        n_total++;
        if (out_valid !== 1'b1 || val_e !== 64'd0 || cc_zf !== 1'b1)
            $display("FAIL drain_accept got v=%b val_e=%h zf=%b want 1/0/1",
                     out_valid, val_e, cc_zf);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL drain_empty got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_bad_ifun();
        // CC is zf=1 sf=0 of=0 on entry.
        drive(1'b1, 4'h6, 4'h7, 64'd3, 64'd4, 64'd0);
        tick();
`ifdef EXEC_ERR_CHECK_EN
        n_total++;
        if (err !== 1'b1 || val_e !== 64'd0 || {cc_zf, cc_sf, cc_of} !== 3'b100)
            $display("FAIL bad_opq got err=%b val_e=%h cc=%b want 1/0/100",
                     err, val_e, {cc_zf, cc_sf, cc_of});
        else n_pass++;
`else
        n_total++;
        if (val_e !== 64'd7 || {cc_zf, cc_sf, cc_of} !== 3'b000)
            $display("FAIL bad_opq got val_e=%h cc=%b want 7/000", val_e, {cc_zf, cc_sf, cc_of});
        else n_pass++;
`endif
        drive(1'b1, 4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
        tick();
`ifdef EXEC_ERR_CHECK_EN
        n_total++;
        if (err !== 1'b1 || cnd !== 1'b0)
            $display("FAIL bad_jxx got err=%b cnd=%b want 1/0", err, cnd);
        else n_pass++;
        drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
        tick();
        n_total++;
        if (err !== 1'b0 || val_e !== 64'd2)
            $display("FAIL err_clear got err=%b val_e=%h want 0/2", err, val_e);
        else n_pass++;
`else
        n_total++;
        if (cnd !== 1'b1)
            $display("FAIL bad_jxx got cnd=%b want 1", cnd);
        else n_pass++;
`endif
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        tick();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        n_total++;
        if (out_valid !== 1'b1 || cc_zf !== 1'b0 || val_e !== 64'd2)
            $display("FAIL prestall got v=%b zf=%b val_e=%h want 1/0/2", out_valid, cc_zf, val_e);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || val_e !== 64'd0 || {cc_zf, cc_sf, cc_of} !== 3'b100
            || in_ready !== 1'b1)
            $display("FAIL rst_stall got v=%b val_e=%h cc=%b rdy=%b want 0/0/100/1",
                     out_valid, val_e, {cc_zf, cc_sf, cc_of}, in_ready);
        else n_pass++;
        out_ready = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_add_overflow();
        test_sub_branch();
        test_addr();
        test_back_to_back_stall();
        test_bad_ifun();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
